// File: rtl/alu_scheduler_pkg.sv
// alu_sched_pkg: shared constants and tag record for the ALU scheduler
package alu_sched_pkg;
    localparam int DEF_NREQ = 4;
    localparam int DEF_STARVE_MAX = 4;
    localparam int ID_W = 4;
    localparam logic [15:0] NOP_INS = 16'h0000;
    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;
endpackage

// File: rtl/alu_scheduler_if.sv
// alu_scheduler_if: requester, ALU and response signals of the scheduler
interface alu_scheduler_if import alu_sched_pkg::*; #(
    parameter int NREQ = DEF_NREQ
);
    logic [NREQ-1:0]    req_valid, req_ready, rsp_valid;
    logic [16*NREQ-1:0] req_ins, req_pc, req_op1, req_op2;
    logic               prio_en, flush;
    logic [15:0]        alu_ins, alu_pc, alu_op1, alu_op2, alu_result, rsp_result;
    modport master (
        output req_valid, req_ins, req_pc, req_op1, req_op2, prio_en, flush, alu_result,
        input  req_ready, alu_ins, alu_pc, alu_op1, alu_op2, rsp_valid, rsp_result
    );
    modport slave (
        input  req_valid, req_ins, req_pc, req_op1, req_op2, prio_en, flush, alu_result,
        output req_ready, alu_ins, alu_pc, alu_op1, alu_op2, rsp_valid, rsp_result
    );
endinterface

// File: rtl/alu_scheduler_rr_arbiter.sv
// rr_arbiter: one-hot grant to the first request at or after the pointer
module rr_arbiter import alu_sched_pkg::*; #(
    parameter int N = DEF_NREQ,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt
);
    logic [N-1:0] w_low, w_first;
    // rotate so the pointer sits at bit 0, isolate the lowest set bit, rotate back
    assign w_low   = N'({i_req, i_req} >> i_ptr);
    assign w_first = w_low & (~w_low + N'(1));
    assign o_gnt   = N'({w_first, w_first} << i_ptr >> N);
endmodule

// File: rtl/alu_scheduler.sv
// alu_scheduler: arbitrates requesters onto a two-stage ALU and routes results back
module alu_scheduler import alu_sched_pkg::*; #(
    parameter int NREQ = DEF_NREQ,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input logic clk,
    input logic rst_n,
    alu_scheduler_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    logic [NREQ-1:0] r_inflight, w_elig, w_rr_req, w_rr_gnt, w_gnt, w_rsp;
    logic [PW-1:0]   r_ptr, w_win;
    logic [SW-1:0]   r_starve;
    tag_t            r_tag [3];
    logic [15:0]     r_alu_ins, r_alu_pc, r_alu_op1, r_alu_op2, w_ins, w_pc, w_op1, w_op2;
    logic            w_xfer, w_others, w_prio, w_force, w_prio_gnt;

    assign w_rsp      = r_tag[2].valid ? NREQ'(1) << r_tag[2].id : '0;
    assign w_elig     = (rst_n && !bus.flush) ? bus.req_valid & (~r_inflight | w_rsp) : '0;
    assign w_others   = |w_elig[NREQ-1:1];
    assign w_prio     = bus.prio_en && w_elig[0];
    assign w_force    = w_prio && r_starve == SMAX && w_others;
    assign w_prio_gnt = w_prio && !w_force;
    assign w_rr_req   = w_force ? {w_elig[NREQ-1:1], 1'b0} : w_elig;

    rr_arbiter #(.N(NREQ), .PW(PW)) u_rr (.i_req(w_rr_req), .i_ptr(r_ptr), .o_gnt(w_rr_gnt));

    assign w_gnt = w_prio_gnt ? NREQ'(1) : w_rr_gnt;
    assign w_xfer = |w_gnt;

    always_comb begin
        w_win = '0;
        w_ins = NOP_INS;
        w_pc  = '0;
        w_op1 = '0;
        w_op2 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_win = PW'(i);
                w_ins = bus.req_ins[16*i +: 16];
                w_pc  = bus.req_pc[16*i +: 16];
                w_op1 = bus.req_op1[16*i +: 16];
                w_op2 = bus.req_op2[16*i +: 16];
            end
        end
    end

    // priority grants to requester 0 leave the round-robin pointer where it was
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
            r_ptr      <= '0;
            r_starve   <= '0;
            r_tag      <= '{default: '0};
            r_alu_ins  <= '0;
            r_alu_pc   <= '0;
            r_alu_op1  <= '0;
            r_alu_op2  <= '0;
        end else begin
            r_tag[0]   <= '{valid: w_xfer, id: ID_W'(w_win)};
            r_tag[1]   <= bus.flush ? '0 : r_tag[0];
            r_tag[2]   <= bus.flush ? '0 : r_tag[1];
            r_inflight <= bus.flush ? '0 : (r_inflight & ~w_rsp) | w_gnt;
            r_alu_ins  <= w_xfer ? w_ins : NOP_INS;
            r_alu_pc   <= w_xfer ? w_pc : '0;
            r_alu_op1  <= w_xfer ? w_op1 : '0;
            r_alu_op2  <= w_xfer ? w_op2 : '0;
            if (w_xfer && !w_prio_gnt)
                r_ptr <= (w_win == PW'(NREQ - 1)) ? '0 : w_win + PW'(1);
            if (!bus.flush)
                r_starve <= !bus.prio_en ? '0 :
                            (w_xfer && !w_gnt[0]) ? '0 :
                            (w_gnt[0] && w_others) ? ((r_starve == SMAX) ? SMAX : r_starve + SW'(1)) :
                            r_starve;
        end
    end

    assign bus.req_ready  = w_gnt;
    assign bus.rsp_valid  = w_rsp;
    assign bus.rsp_result = bus.alu_result;
    assign bus.alu_ins    = r_alu_ins;
    assign bus.alu_pc     = r_alu_pc;
    assign bus.alu_op1    = r_alu_op1;
    assign bus.alu_op2    = r_alu_op2;
endmodule
